// File: rtl/counter_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer_pkg
// Description : Shared state encoding, constants and width helper for the
//               counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_sequencer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic c_DIR_UP       = 1'b0;
    localparam logic c_DIR_DOWN     = 1'b1;
    localparam logic c_MODE_ONESHOT = 1'b0;
    localparam logic c_MODE_RELOAD  = 1'b1;

    // Prescaler width; a divide-by-one still keeps a 1-bit register.
    function automatic int ps_width(input int prescale);
        return (prescale == 1) ? 1 : $clog2(prescale);
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : PRESCALE-cycle prescaler producing the count tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
    import counter_sequencer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PS_W = ps_width(PRESCALE);
    localparam logic [PS_W-1:0] c_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] r_ps;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ps <= '0;
        end else if (en) begin
            r_ps <= (r_ps == c_LAST) ? '0 : r_ps + PS_W'(1);
        end
    end

    // With PRESCALE==1 the register stays at zero and every enabled cycle ticks.
    assign tick = en && (r_ps == c_LAST);

endmodule
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer
// Description : Start/stop sequencer owning an up/down counter, its tick
//               prescaler and a saturating completed-period counter.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1,
    parameter int PCNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              mode_reload,
    input  logic              dir,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PCNT_W-1:0] period_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_count_nxt;
    logic [WIDTH-1:0]   r_limit;
    logic [WIDTH-1:0]   w_limit_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    logic               r_reload;
    logic               w_reload_nxt;
    logic               r_busy;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic [PCNT_W-1:0]  r_period;
    logic               w_period_inc;
    logic               w_tick;
    logic [WIDTH-1:0]   w_term;
    logic [WIDTH-1:0]   w_start_val;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  ((r_state != RUN) || stop),
        .en   (r_state == RUN),
        .tick (w_tick)
    );

    assign w_term      = (r_dir == c_DIR_DOWN) ? '0 : r_limit;
    assign w_start_val = (r_dir == c_DIR_DOWN) ? r_limit : '0;

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_limit_nxt  = r_limit;
        w_dir_nxt    = r_dir;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_period_inc = 1'b0;
        case (r_state)
            IDLE: begin
                // A coincident stop suppresses the start entirely, including err.
                if (start && !stop) begin
                    if (limit == '0) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = RUN;
                        w_limit_nxt  = limit;
                        w_dir_nxt    = dir;
                        w_reload_nxt = mode_reload;
                        w_count_nxt  = (dir == c_DIR_DOWN) ? limit : '0;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    if (r_count == w_term) begin
                        w_done_nxt   = 1'b1;
                        w_period_inc = 1'b1;
                        if (r_reload == c_MODE_RELOAD) begin
                            w_count_nxt = w_start_val;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else if (r_dir == c_DIR_DOWN) begin
                        w_count_nxt = r_count - WIDTH'(1);
                    end else begin
                        w_count_nxt = r_count + WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_limit  <= '0;
            r_dir    <= c_DIR_UP;
            r_reload <= c_MODE_ONESHOT;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_period <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_limit  <= w_limit_nxt;
            r_dir    <= w_dir_nxt;
            r_reload <= w_reload_nxt;
            r_busy   <= (w_state_nxt == RUN);
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            if (w_period_inc && (r_period != '1)) begin
                r_period <= r_period + PCNT_W'(1);
            end
        end
    end

    assign count      = r_count;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign period_cnt = r_period;

endmodule
`default_nettype wire
